psum_acc_sram: RTL and testbench
================================

Name: psum_acc_sram

Overview:
- Parametrised partial-sum buffer: DEPTH words of COL signed lanes, each PSUM_BW bits wide.
- Supports read, overwrite and lane-wise accumulate (read-modify-write).
- Sits between the MAC array output and the output-feature buffer.
- Accumulate uses a 2-stage pipeline with a single pending-commit register and full forwarding, so back-to-back accumulates to one address need no stalls.

Parameters:
COL, 8, number of signed lanes per word
PSUM_BW, 20, bits per lane (word = COL*PSUM_BW)
DEPTH, 16, number of words
ADDR_BW, 4, address width; DEPTH <= 2**ADDR_BW

Ports:
CLK  in  1  clock, all logic on posedge
RESET  in  1  synchronous, active-high reset
CEN  in  1  chip enable, active low
WEN  in  1  0 = write/accumulate, 1 = read
ACC  in  1  with WEN=0: 1 = accumulate, 0 = overwrite; ignored on reads
A  in  ADDR_BW  word address
D  in  COL*PSUM_BW  write/accumulate data; lane k = D[(k+1)*PSUM_BW-1 : k*PSUM_BW]
Q  out  COL*PSUM_BW  read data, registered
Q_VALID  out  1  single-cycle pulse, 1 cycle after an accepted read

Behaviour:
- Reset:
  - Q=0, Q_VALID=0.
  - Pending register invalidated.
  - All per-entry valid bits cleared.
  - Array contents are not reset.
  - RESET overrides any op presented in the same cycle.
  - A pending accumulate at reset is discarded, not committed.
- Idle: CEN=1 means no op. Pending commit still drains. Q holds its value; Q_VALID=0.
- Logical word value:
  - Invalid entry reads as 0.
  - "Current value" of A = pending result if pending is valid and pend_addr==A; otherwise the array entry, gated by its valid bit.
- Read (CEN=0, WEN=1): at edge t, Q <= current value of A; Q_VALID=1 during cycle t..t+1. Read latency is 1 cycle. A read always observes every write/accumulate accepted earlier.
- Overwrite (CEN=0, WEN=0, ACC=0): at edge t, mem[A] <= D and valid[A] <= 1, visible to a read accepted at t+1.
- Accumulate (CEN=0, WEN=0, ACC=1):
  - At edge t the pending register captures A and lane-wise (current value + D).
  - The array commit happens at edge t+1.
  - Each lane adds as signed PSUM_BW and wraps modulo 2**PSUM_BW (see optional feature).
- Simultaneous events at one edge:
  - The pending commit and a new overwrite to the same address: the overwrite wins.
  - Pending commit and a new accumulate to the same address: the new accumulate uses the forwarded pending value; no double-count.
  - Commits to different addresses proceed independently.
- Out-of-range A (A >= DEPTH):
  - Writes and accumulates are dropped.
  - Reads return Q=0 with Q_VALID=1.
- No backpressure: every CEN=0 cycle is accepted.

Optional Feature:
- Macro: PSUM_ACC_SAT_EN.
- Defined: accumulate saturates per lane to [-2**(PSUM_BW-1), 2**(PSUM_BW-1)-1]. Overflow is detected from the operand sign bits and the sum sign bit.
- Undefined: two's-complement wraparound. Overwrite and read are unaffected either way.

Test Plan:
- Reset, then read addr 3 -> Q=0, Q_VALID pulses 1 cycle. Then overwrite addr 3 all lanes 100, read next cycle -> every lane 100.
- Overwrite addr 5 lanes=10. Then 4 back-to-back accumulates to addr 5 of lanes=1,2,3,4, then immediate read -> every lane 20 with no idle cycles inserted.
- Accumulate into never-written addr 7 with lane k = -k, then read -> lane k = -k. Accumulate on addr 2 immediately followed by overwrite addr 2 with 55, then read -> 55.
- Accumulate to addr 1 in the same cycle as RESET=1 -> after reset, read addr 1 returns 0. Accumulate to addr 1 followed by RESET next cycle -> read returns 0.
- Lane 0 at 524287, accumulate +1 -> lane 0 = -524288 without PSUM_ACC_SAT_EN, 524287 with it. With the macro, -524288 + (-1) -> -524288.
- Overwrite to A=DEPTH (16 with ADDR_BW=5 build) is dropped. Read A=DEPTH -> Q=0, Q_VALID=1, all in-range entries unchanged.

Source files
------------

// File: rtl/psum_acc_sram.sv
// ============================================================================
// Module   : psum_acc_sram
// Purpose  : Partial-sum buffer of DEPTH words x COL signed lanes. Supports
//            read, overwrite and a lane-wise accumulate through a single
//            pending-commit register with full forwarding.
// Options  : define PSUM_ACC_SAT_EN for saturating accumulate (else wrap)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_acc_sram #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 20,
    parameter int DEPTH   = 16,
    parameter int ADDR_BW = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CEN,
    input  logic                     WEN,
    input  logic                     ACC,
    input  logic [ADDR_BW-1:0]       A,
    input  logic [COL*PSUM_BW-1:0]   D,
    output logic [COL*PSUM_BW-1:0]   Q,
    output logic                     Q_VALID
);

    localparam int IDX_BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W = COL * PSUM_BW;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic              pend_valid_q;
    logic [IDX_BW-1:0] pend_addr_q;
    logic [WORD_W-1:0] pend_data_q;
    logic [WORD_W-1:0] pend_data_d;
    logic [WORD_W-1:0] q_q;
    logic              qv_q;

    logic              w_in_range;
    logic [IDX_BW-1:0] w_idx;
    logic              w_rd;
    logic              w_wr;
    logic              w_acc;
    logic [WORD_W-1:0] w_cur;

    assign w_in_range = (32'(A) < DEPTH);
    assign w_idx      = A[IDX_BW-1:0];
    assign w_rd       = !CEN && WEN;
    assign w_wr       = !CEN && !WEN && !ACC && w_in_range;
    assign w_acc      = !CEN && !WEN && ACC && w_in_range;

    // Logical word value: the pending result shadows the array entry.
    always_comb begin
        w_cur = '0;
        if (w_in_range) begin
            if (pend_valid_q && (pend_addr_q == w_idx))
                w_cur = pend_data_q;
            else if (valid_q[w_idx])
                w_cur = mem_q[w_idx];
        end
    end

    for (genvar k = 0; k < COL; k++) begin : g_lane
        logic signed [PSUM_BW-1:0] w_a;
        logic signed [PSUM_BW-1:0] w_b;
        logic signed [PSUM_BW-1:0] w_s;

        assign w_a = w_cur[k*PSUM_BW +: PSUM_BW];
        assign w_b = D[k*PSUM_BW +: PSUM_BW];
        assign w_s = w_a + w_b;
`ifdef PSUM_ACC_SAT_EN
        localparam logic [PSUM_BW-1:0] c_max = {1'b0, {(PSUM_BW-1){1'b1}}};
        localparam logic [PSUM_BW-1:0] c_min = {1'b1, {(PSUM_BW-1){1'b0}}};
        logic w_ovf;
        assign w_ovf = (w_a[PSUM_BW-1] == w_b[PSUM_BW-1]) &&
                       (w_s[PSUM_BW-1] != w_a[PSUM_BW-1]);
        assign pend_data_d[k*PSUM_BW +: PSUM_BW] =
            w_ovf ? (w_a[PSUM_BW-1] ? c_min : c_max) : w_s;
`else
        assign pend_data_d[k*PSUM_BW +: PSUM_BW] = w_s;
`endif
    end

    // Commit is ordered before the new write so a same-address overwrite wins;
    // holding the commit off during reset discards any pending accumulate.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q          <= '0;
            qv_q         <= 1'b0;
            valid_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            qv_q <= w_rd;
            if (w_rd)
                q_q <= w_cur;
            if (pend_valid_q) begin
                mem_q[pend_addr_q]   <= pend_data_q;
                valid_q[pend_addr_q] <= 1'b1;
            end
            if (w_wr) begin
                mem_q[w_idx]   <= D;
                valid_q[w_idx] <= 1'b1;
            end
            pend_valid_q <= w_acc;
            if (w_acc) begin
                pend_addr_q <= w_idx;
                pend_data_q <= pend_data_d;
            end
        end
    end

    assign Q       = q_q;
    assign Q_VALID = qv_q;

endmodule

`default_nettype wire

// File: tb/tb_psum_acc_sram.sv
// ============================================================================
// Module   : tb_psum_acc_sram
// Purpose  : Directed and random checks of psum_acc_sram against a word-level
//            model (PSUM_ACC_SAT_EN selects saturating expectations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_acc_sram;

    localparam int COL   = 8;
    localparam int BW    = 20;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int W     = COL * BW;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          CEN;
    logic          WEN;
    logic          ACC;
    logic [AW-1:0] A;
    logic [W-1:0]  D;
    logic [W-1:0]  Q;
    logic          Q_VALID;

    logic [W-1:0]  mdl [DEPTH];
    logic [W-1:0]  exp_q;
    logic          exp_qv;
    int            checks;
    int            failures;

    psum_acc_sram #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH), .ADDR_BW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .CEN(CEN), .WEN(WEN), .ACC(ACC),
        .A(A), .D(D), .Q(Q), .Q_VALID(Q_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] rep(input longint v);
        logic [W-1:0] r;
        logic [63:0]  vv;
        vv = v;
        for (int k = 0; k < COL; k++) r[k*BW +: BW] = vv[BW-1:0];
        return r;
    endfunction

    // Lane sums computed on plain integers, then wrapped or clamped.
    function automatic logic [W-1:0] add_words(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0]         r;
        logic signed [BW-1:0] lx, ly;
        longint               s;
        logic [63:0]          su;
        for (int k = 0; k < COL; k++) begin
            lx = x[k*BW +: BW];
            ly = y[k*BW +: BW];
            s  = longint'(lx) + longint'(ly);
`ifdef PSUM_ACC_SAT_EN
            if (s > (64'sd1 <<< (BW-1)) - 1) s = (64'sd1 <<< (BW-1)) - 1;
            if (s < -(64'sd1 <<< (BW-1)))    s = -(64'sd1 <<< (BW-1));
`endif
            su = s;
            r[k*BW +: BW] = su[BW-1:0];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic op(input logic rst, input logic cen, input logic wen, input logic acc,
                      input int a, input logic [W-1:0] d);
        RESET = rst; CEN = cen; WEN = wen; ACC = acc; A = a[AW-1:0]; D = d;
        @(posedge CLK);
        #1;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
            exp_q  = '0;
            exp_qv = 1'b0;
        end else begin
            exp_qv = 1'b0;
            if (!cen) begin
                if (wen) begin
                    exp_q  = (a < DEPTH) ? mdl[a] : '0;
                    exp_qv = 1'b1;
                end else if (a < DEPTH) begin
                    mdl[a] = acc ? add_words(mdl[a], d) : d;
                end
            end
        end
        check($sformatf("q a=%0d", a), Q, exp_q);
        check($sformatf("qv a=%0d", a), {{(W-1){1'b0}}, Q_VALID}, {{(W-1){1'b0}}, exp_qv});
    endtask

    task automatic rd(input int a);  op(1'b0, 1'b0, 1'b1, 1'b0, a, '0); endtask
    task automatic ow(input int a, input logic [W-1:0] d); op(1'b0, 1'b0, 1'b0, 1'b0, a, d); endtask
    task automatic ac(input int a, input logic [W-1:0] d); op(1'b0, 1'b0, 1'b0, 1'b1, a, d); endtask

    initial begin
        logic [W-1:0] dv;
        logic [W-1:0] rnd;
        int           sel;
        checks   = 0;
        failures = 0;
        exp_q    = '0;
        exp_qv   = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        RESET = 1'b1; CEN = 1'b1; WEN = 1'b1; ACC = 1'b0; A = '0; D = '0;

        op(1'b1, 1'b1, 1'b1, 1'b0, 0, '0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 0, '0);

        // Read of reset word, then overwrite/read
        rd(3);
        op(1'b0, 1'b1, 1'b1, 1'b0, 0, '0);
        ow(3, rep(100));
        rd(3);

        // Back-to-back accumulates with immediate read
        ow(5, rep(10));
        ac(5, rep(1)); ac(5, rep(2)); ac(5, rep(3)); ac(5, rep(4));
        rd(5);
        check("acc5_eq20", Q, rep(20));

        // Accumulate into unwritten word; accumulate then overwrite
        for (int k = 0; k < COL; k++) dv[k*BW +: BW] = BW'(-k);
        ac(7, dv);
        rd(7);
        ac(2, rep(9));
        ow(2, rep(55));
        rd(2);
        check("ow_wins_55", Q, rep(55));

        // Reset discards pending accumulates
        ac(1, rep(5));
        op(1'b1, 1'b0, 1'b0, 1'b1, 1, rep(5));
        rd(1);
        ac(1, rep(5));
        op(1'b1, 1'b1, 1'b1, 1'b0, 0, '0);
        rd(1);
        check("rst_discard", Q, '0);

        // Lane overflow at both extremes
        dv = '0; dv[BW-1:0] = 20'h7FFFF;
        ow(0, dv);
        dv = '0; dv[BW-1:0] = 20'd1;
        ac(0, dv);
        rd(0);
        dv = '0; dv[BW-1:0] = 20'h80000;
        ow(0, dv);
        dv = '0; dv[BW-1:0] = 20'hFFFFF;
        ac(0, dv);
        rd(0);

        // Out-of-range address
        ow(16, rep(77));
        ac(17, rep(3));
        rd(16);
        for (int i = 0; i < DEPTH; i++) rd(i);

        // Randomised mix, including occasional reset and hot-address reuse
        for (int n = 0; n < 400; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            sel = $urandom_range(0, 99);
            if (sel < 2)
                op(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1,
                   $urandom_range(0, DEPTH - 1), rnd);
            else if (sel < 15)
                op(1'b0, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, DEPTH + 1), rnd);
            else if (sel < 45)
                rd($urandom_range(0, DEPTH + 1));
            else if (sel < 60)
                ow($urandom_range(0, DEPTH + 1), rnd);
            else
                ac((sel < 80) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH + 1), rnd);
        end
        for (int i = 0; i < DEPTH; i++) rd(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
